// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG spike-timing blocks: interval FSM encoding,
// default counter width and the counter saturation value.
package ecg_pkg;

   // Default interval counter / data width.
   localparam int unsigned CNT_W_DEF = 16;

   // Interval measurement FSM: waiting for a first edge, or timing an interval.
   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StCount = 1'b1
   } isi_state_e;

   // Saturation value of a w-bit counter (all ones).
   // 1 << 32 wraps to 0 in 32 bits, so w = 32 still yields all ones.
   function automatic logic [31:0] sat_count(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/isi_fifo.sv
// First-word-fall-through FIFO for measured inter-spike intervals.
// The head entry is visible on rdata whenever the FIFO is non-empty.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module isi_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             wr_en, rd_en;

   assign full  = (level_q == LvlFull);
   assign empty = (level_q == '0);
   assign level = level_q;

   // A push into a full FIFO is still accepted when the head leaves the same cycle.
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;

   // Occupancy next state: simultaneous push and pop leaves level unchanged.
   always_comb begin
      level_d = level_q;
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Storage array; contents are never observed while empty, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= wdata;
   end

   // Gate the head so an empty FIFO presents zero rather than stale data.
   assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/spike_isi_meter.sv
// Inter-spike interval meter: times the gap between rising spike edges,
// queues each interval in a FWFT FIFO and keeps a running mean over the
// last 2^AVG_N_LOG2 intervals, with sticky overflow and timeout flags.
module spike_isi_meter
   import ecg_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AVG_N_LOG2 = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    spike,
   input  logic                    clr,
   input  logic                    isi_ready,
   output logic                    isi_valid,
   output logic [CNT_W-1:0]        isi_data,
   output logic [CNT_W-1:0]        mean_isi,
   output logic                    mean_valid,
   output logic                    overflow,
   output logic                    timeout,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned AVG_N  = 1 << AVG_N_LOG2;
   localparam int unsigned SUM_W  = CNT_W + AVG_N_LOG2;
   localparam int unsigned FILL_W = AVG_N_LOG2 + 1;
   localparam logic [CNT_W-1:0]  CntMax   = CNT_W'(sat_count(CNT_W));
   localparam logic [FILL_W-1:0] FillFull = FILL_W'(AVG_N);

   // Edge detection
   logic spike_d;
   logic spike_edge;

   // Interval FSM and counter
   isi_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             isi_push;
   logic             timeout_set;

   // FIFO handshake
   logic fifo_full, fifo_empty, fifo_pop, drop;

   // Sticky flags
   logic overflow_q, overflow_d;
   logic timeout_q, timeout_d;

   // Running-mean window
   logic [CNT_W-1:0]  win_q    [AVG_N];
   logic [CNT_W-1:0]  win_base [AVG_N];
   logic [CNT_W-1:0]  win_d    [AVG_N];
   logic [SUM_W-1:0]  sum_q, sum_base, sum_d;
   logic [FILL_W-1:0] fill_q, fill_base, fill_d;

   // A spike held high for several cycles counts once, on its rising cycle.
   assign spike_edge = spike & ~spike_d;

   // Delay register for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) spike_d <= 1'b0;
      else        spike_d <= spike;
   end

   // Interval FSM: the first edge only arms the counter; later edges emit cnt.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      isi_push    = 1'b0;
      timeout_set = 1'b0;
      case (state_q)
         StIdle: begin
            if (spike_edge) begin
               cnt_d   = CNT_W'(1);
               state_d = StCount;
            end
         end
         StCount: begin
            if (spike_edge) begin
               isi_push = 1'b1;
               cnt_d    = CNT_W'(1);
            end else if (cnt_q == CntMax) begin
               // No spike for the full counter range: give up on this interval.
               timeout_set = 1'b1;
               cnt_d       = '0;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state and interval counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign isi_valid = ~fifo_empty;
   assign fifo_pop  = isi_valid & isi_ready;
   assign drop      = isi_push & fifo_full & ~fifo_pop;

   isi_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (isi_push),
      .wdata (cnt_q),
      .pop   (fifo_pop),
      .rdata (isi_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Sticky flags: a flag being set in the same cycle as clr stays set.
   always_comb begin
      overflow_d = overflow_q;
      timeout_d  = timeout_q;
      if (clr) begin
         overflow_d = 1'b0;
         timeout_d  = 1'b0;
      end
      if (drop)        overflow_d = 1'b1;
      if (timeout_set) timeout_d  = 1'b1;
   end

   // Sticky flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   assign overflow = overflow_q;
   assign timeout  = timeout_q;

   // Mean window: clr empties it first, then any interval measured this cycle
   // (queued or dropped) shifts in and the sum is adjusted incrementally.
   always_comb begin
      sum_base  = clr ? '0 : sum_q;
      fill_base = clr ? '0 : fill_q;
      for (int i = 0; i < AVG_N; i++) begin
         win_base[i] = clr ? '0 : win_q[i];
      end

      win_d  = win_base;
      sum_d  = sum_base;
      fill_d = fill_base;

      // A timeout invalidates the mean until a full set of new intervals arrives.
      if (timeout_set) fill_d = '0;

      if (isi_push) begin
         sum_d = sum_base + SUM_W'(cnt_q) - SUM_W'(win_base[AVG_N-1]);
         for (int i = 1; i < AVG_N; i++) begin
            win_d[i] = win_base[i-1];
         end
         win_d[0] = cnt_q;
         if (fill_base != FillFull) fill_d = fill_base + FILL_W'(1);
      end
   end

   // Mean window, sum and fill-count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < AVG_N; i++) begin
            win_q[i] <= '0;
         end
         sum_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         sum_q  <= sum_d;
         fill_q <= fill_d;
      end
   end

   // Truncating divide by the window length.
   assign mean_isi   = CNT_W'(sum_q >> AVG_N_LOG2);
   assign mean_valid = (fill_q == FillFull);

endmodule

// File: doc/spike_isi_meter.md
SPIKE_ISI_METER -- requirements
Module: spike_isi_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, interval counter/data width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries (power of two).
REQ-003 SHALL have parameter AVG_N_LOG2, default 2, log2 of running-mean window (4 intervals).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port spike  input  1  spike flag from the neuron stage; may be high for one or more cycles.
REQ-007 SHALL have port clr  input  1  synchronous clear of sticky flags and mean window.
REQ-008 SHALL have port isi_ready  input  1  consumer accepts isi_data.
REQ-009 SHALL have port isi_valid  output  1  FIFO head valid.
REQ-010 SHALL have port isi_data  output  CNT_W  interval at FIFO head, unsigned clock cycles.
REQ-011 SHALL have port mean_isi  output  CNT_W  running mean of last 2^AVG_N_LOG2 intervals.
REQ-012 SHALL have port mean_valid  output  1  window fully populated.
REQ-013 SHALL have port overflow  output  1  sticky: interval dropped on full FIFO.
REQ-014 SHALL have port timeout  output  1  sticky: counter saturated without spike.
REQ-015 SHALL have port level  output  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 SHALL register spike into spike_d; edge = spike & ~spike_d, so a held spike counts once.
REQ-017 SHALL implement FSM IDLE/COUNT; reset state IDLE.
REQ-018 IDLE: on edge SHALL load cnt<=1, go COUNT, push nothing.
REQ-019 COUNT, no edge: cnt<=cnt+1; at cnt=2^CNT_W-1 SHALL set timeout, go IDLE, push nothing.
REQ-020 COUNT, edge: SHALL push cnt (= cycles between edges), load cnt<=1, stay COUNT.
REQ-021 Push SHALL write isi_data in cycle after edge; edges 5 cycles apart yield value 5.
REQ-022 FIFO SHALL be first-word-fall-through: isi_valid = level!=0, isi_data = head entry.
REQ-023 Pop SHALL occur when isi_valid & isi_ready.
REQ-024 Push when full and no pop SHALL drop the value and set overflow; push with pop when full SHALL be accepted.
REQ-025 Push and pop on same cycle when non-empty SHALL leave level unchanged; pointers wrap mod DEPTH.
REQ-026 Every measured interval (including dropped ones) SHALL enter the mean window shift register.
REQ-027 Window sum SHALL be CNT_W+AVG_N_LOG2 bits, updated incrementally (add new, subtract oldest); mean_isi = sum>>AVG_N_LOG2, truncated.
REQ-028 mean_valid SHALL assert after 2^AVG_N_LOG2 intervals; cleared by timeout entry, clr or reset.
REQ-029 clr SHALL clear overflow, timeout, window, sum, mean_valid; SHALL NOT affect FIFO or FSM; a same-cycle flag set wins over clr.

Reset
REQ-030 reset low SHALL immediately force: FSM IDLE, cnt=0, spike_d=0, pointers/level=0, isi_valid=0, isi_data=0, mean_isi=0, mean_valid=0, overflow=0, timeout=0.
REQ-031 Reset mid-interval SHALL discard the partial count; first edge after release only starts counting.
REQ-032 Reset release SHALL be synchronised externally; block SHALL add no internal reset synchroniser.

Structure
REQ-033 FSM state encoding, CNT_W default and saturation constant SHALL live in shared package ecg_pkg.
REQ-034 FIFO SHALL be one sub-module isi_fifo (DEPTH, width, FWFT, full/empty/level); FSM, counter, mean in top.

Verification
REQ-035 Edges at cycles 10,15,27, ready=1 -> isi_data 5 then 12, each valid one cycle after its edge.
REQ-036 spike held high 6 cycles, next rise 20 cycles after first -> exactly one push, value 20.
REQ-037 ready=0, 9 intervals of 4 -> level=8, overflow=1, 9th dropped; then ready=1 drains eight 4s.
REQ-038 Intervals 4,8,12,16 -> mean_valid=1, mean_isi=10; next 20 -> mean_isi=14.
REQ-039 No edge for 65535 cycles after start -> timeout=1, FSM IDLE, no push; clr -> timeout=0.
REQ-040 reset asserted mid-count with 3 entries queued -> all outputs 0 immediately; next edge pair 7 apart -> single push 7.
